// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha sequencer and the quarter array.
// Read-address field positions are common to both sides of the read bus.
package chacha_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_CALC  = 3'd2,
        S_SHIFT = 3'd3,
        S_ADDB  = 3'd4,
        S_OUT   = 3'd5,
        S_INC   = 3'd6
    } seq_state_e;

    localparam int CALC_CYCLES  = 4;
    localparam int SHIFT_CYCLES = 32;
    localparam int BLOCK_BYTES  = 64;

    localparam int ADDR_W        = 6;
    localparam int ADDR_FIELD_W  = 2;
    localparam int ADDR_BYTE_LSB = 0;
    localparam int ADDR_COL_LSB  = 2;
    localparam int ADDR_ROW_LSB  = 4;

    // word = row*4 + col, bytes little-endian inside a word
    function automatic logic [ADDR_W-1:0] addr_pack(
        input logic [ADDR_FIELD_W-1:0] row,
        input logic [ADDR_FIELD_W-1:0] col,
        input logic [ADDR_FIELD_W-1:0] byte_idx
    );
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_ROW_LSB +: ADDR_FIELD_W]  = row;
        a[ADDR_COL_LSB +: ADDR_FIELD_W]  = col;
        a[ADDR_BYTE_LSB +: ADDR_FIELD_W] = byte_idx;
        return a;
    endfunction

endpackage

// File: rtl/chacha_sequencer_if.sv
// Control, read-bus and keystream-stream signals between the sequencer and its surroundings.
// With CHACHA_XOR_EN defined the bundle also carries the plaintext byte pt_data.
interface chacha_sequencer_if;

    logic       start;
    logic       busy;
    logic       done;
    logic       calc;
    logic [1:0] step;
    logic       shift;
    logic       shift_dir;
    logic [4:0] shift_ctr;
    logic       add_back;
    logic       clear;
    logic       inc_ctr;
    logic [5:0] addr;
    logic [7:0] data_rd;
    logic       ks_valid;
    logic       ks_ready;
    logic [7:0] ks_data;
    logic       ks_last;
`ifdef CHACHA_XOR_EN
    logic [7:0] pt_data;
`endif

    modport master (
`ifdef CHACHA_XOR_EN
        input  pt_data,
`endif
        input  start, data_rd, ks_ready,
        output busy, done, calc, step, shift, shift_dir, shift_ctr,
        output add_back, clear, inc_ctr, addr, ks_valid, ks_data, ks_last
    );

    modport slave (
`ifdef CHACHA_XOR_EN
        output pt_data,
`endif
        output start, data_rd, ks_ready,
        input  busy, done, calc, step, shift, shift_dir, shift_ctr,
        input  add_back, clear, inc_ctr, addr, ks_valid, ks_data, ks_last
    );

endinterface

// File: rtl/chacha_ks_port.sv
// Keystream output port: byte address counter, valid/ready handshake and ks_last.
// With CHACHA_XOR_EN defined the read byte is XORed with pt_data to emit ciphertext.
module chacha_ks_port
    import chacha_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [7:0]        data_rd_i,
    input  logic              ks_ready_i,
`ifdef CHACHA_XOR_EN
    input  logic [7:0]        pt_data_i,
`endif
    output logic [ADDR_W-1:0] addr_o,
    output logic              ks_valid_o,
    output logic [7:0]        ks_data_o,
    output logic              ks_last_o,
    output logic              last_acc_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              accept;
    logic [7:0]        byte_out;

    assign accept = en_i && ks_ready_i;

    // Counter is held at zero outside OUT so every block starts at byte 0.
    always_comb begin
        addr_d = addr_q;
        if (!en_i) begin
            addr_d = '0;
        end else if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

`ifdef CHACHA_XOR_EN
    assign byte_out = data_rd_i ^ pt_data_i;
`else
    assign byte_out = data_rd_i;
`endif

    assign addr_o     = en_i ? addr_pack(addr_q[ADDR_ROW_LSB +: ADDR_FIELD_W],
                                         addr_q[ADDR_COL_LSB +: ADDR_FIELD_W],
                                         addr_q[ADDR_BYTE_LSB +: ADDR_FIELD_W]) : '0;
    assign ks_valid_o = en_i;
    assign ks_data_o  = en_i ? byte_out : 8'h00;
    assign ks_last_o  = en_i && (addr_q == ADDR_W'(BLOCK_BYTES - 1));
    assign last_acc_o = accept && ks_last_o;

endmodule

// File: rtl/chacha_sequencer.sv
// ChaCha block sequencer: CLEAR, ROUNDS x (CALC, SHIFT), ADDB, OUT, INC.
// Optional CHACHA_XOR_EN: keystream port XORs pt_data into the output bytes.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | reload working state from the initial state
// CALC    | quarter-round steps 0..3
// SHIFT   | 32-cycle inter-round word shuffle, direction = round parity
// ADDB    | add initial state back into working state
// OUT     | stream 64 keystream bytes over valid/ready
// INC     | bump block counter, pulse done
module chacha_sequencer
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20   // even, >= 2
) (
    input  logic               clk,
    input  logic               rst,
    chacha_sequencer_if.master bus
);

    localparam int RW = $clog2(ROUNDS);

    seq_state_e    state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [4:0]    shift_ctr_q, shift_ctr_d;
    logic [RW-1:0] round_q, round_d;

    logic clear_s, calc_s, shift_s, add_back_s, inc_ctr_s;
    logic out_en, out_last_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            shift_ctr_q <= '0;
            round_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            shift_ctr_q <= shift_ctr_d;
            round_q     <= round_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        shift_ctr_d = shift_ctr_q;
        round_d     = round_q;
        clear_s     = 1'b0;
        calc_s      = 1'b0;
        shift_s     = 1'b0;
        add_back_s  = 1'b0;
        inc_ctr_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear_s = 1'b1;
                step_d  = '0;
                round_d = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                calc_s = 1'b1;
                if (step_q == 2'(CALC_CYCLES - 1)) begin
                    step_d      = '0;
                    shift_ctr_d = '0;
                    state_d     = S_SHIFT;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_SHIFT: begin
                shift_s = 1'b1;
                if (shift_ctr_q == 5'(SHIFT_CYCLES - 1)) begin
                    shift_ctr_d = '0;
                    // The last round also shifts; its odd parity restores column order.
                    if (round_q == RW'(ROUNDS - 1)) begin
                        round_d = '0;
                        state_d = S_ADDB;
                    end else begin
                        round_d = round_q + RW'(1);
                        state_d = S_CALC;
                    end
                end else begin
                    shift_ctr_d = shift_ctr_q + 5'd1;
                end
            end
            S_ADDB: begin
                add_back_s = 1'b1;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_last_acc) begin
                    state_d = S_INC;
                end
            end
            S_INC: begin
                inc_ctr_s = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_en = (state_q == S_OUT);

    chacha_ks_port u_ks_port (
        .clk        (clk),
        .rst        (rst),
        .en_i       (out_en),
        .data_rd_i  (bus.data_rd),
        .ks_ready_i (bus.ks_ready),
`ifdef CHACHA_XOR_EN
        .pt_data_i  (bus.pt_data),
`endif
        .addr_o     (bus.addr),
        .ks_valid_o (bus.ks_valid),
        .ks_data_o  (bus.ks_data),
        .ks_last_o  (bus.ks_last),
        .last_acc_o (out_last_acc)
    );

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = inc_ctr_s;
    assign bus.clear     = clear_s;
    assign bus.calc      = calc_s;
    assign bus.step      = calc_s ? step_q : 2'd0;
    assign bus.shift     = shift_s;
    assign bus.shift_dir = shift_s & round_q[0];
    assign bus.shift_ctr = shift_s ? shift_ctr_q : 5'd0;
    assign bus.add_back  = add_back_s;
    assign bus.inc_ctr   = inc_ctr_s;

endmodule

// File: tb/tb_chacha_sequencer.sv
// Bench for chacha_sequencer: cycle-offset model of the block timeline plus directed literals.
module tb_chacha_sequencer;

    localparam int RND      = 20;
    localparam int OFF_ADDB = 2 + 36 * RND;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    int   m_off = -1;
    int   m_nacc = 0;
    int   n_inc = 0;

    logic [7:0] mem [64];
`ifdef CHACHA_XOR_EN
    logic [7:0] pt_mem [64];
`endif

    chacha_sequencer_if bus();

    chacha_sequencer #(.ROUNDS(RND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.data_rd = mem[bus.addr];
`ifdef CHACHA_XOR_EN
    assign bus.pt_data = pt_mem[bus.addr];
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
`ifdef CHACHA_XOR_EN
        return mem[k] ^ pt_mem[k];
`else
        return mem[k];
`endif
    endfunction

    // Model: m_off = cycles since start was accepted (-1 idle), m_nacc = bytes accepted.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_off  <= -1;
            m_nacc <= 0;
        end else if (m_off < 0) begin
            if (bus.start) m_off <= 1;
        end else if (m_off > OFF_ADDB && m_nacc == 64) begin
            m_off  <= -1;
            m_nacc <= 0;
        end else begin
            m_off <= m_off + 1;
            if (m_off > OFF_ADDB && bus.ks_ready) m_nacc <= m_nacc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_busy, e_done, e_clear, e_calc, e_shift, e_dir, e_addb, e_inc;
            logic       e_valid, e_last;
            logic [1:0] e_step;
            logic [4:0] e_ctr;
            logic [5:0] e_addr;
            logic [7:0] e_data;
            int         p;
            e_busy = 0; e_done = 0; e_clear = 0; e_calc = 0; e_shift = 0; e_dir = 0;
            e_addb = 0; e_inc = 0; e_valid = 0; e_last = 0;
            e_step = '0; e_ctr = '0; e_addr = '0; e_data = '0;
            if (m_off >= 1) e_busy = 1;
            if (m_off == 1) begin
                e_clear = 1;
            end else if (m_off >= 2 && m_off < OFF_ADDB) begin
                p = (m_off - 2) % 36;
                if (p < 4) begin
                    e_calc = 1;
                    e_step = 2'(p);
                end else begin
                    e_shift = 1;
                    e_ctr   = 5'(p - 4);
                    e_dir   = (((m_off - 2) / 36) % 2) == 1;
                end
            end else if (m_off == OFF_ADDB) begin
                e_addb = 1;
            end else if (m_off > OFF_ADDB) begin
                if (m_nacc < 64) begin
                    e_valid = 1;
                    e_addr  = 6'(m_nacc);
                    e_data  = exp_byte(m_nacc);
                    e_last  = (m_nacc == 63);
                end else begin
                    e_inc  = 1;
                    e_done = 1;
                end
            end
            chk("busy", bus.busy, e_busy);
            chk("done", bus.done, e_done);
            chk("clear", bus.clear, e_clear);
            chk("calc", bus.calc, e_calc);
            chk("step", bus.step, e_step);
            chk("shift", bus.shift, e_shift);
            chk("shift_dir", bus.shift_dir, e_dir);
            chk("shift_ctr", bus.shift_ctr, e_ctr);
            chk("add_back", bus.add_back, e_addb);
            chk("inc_ctr", bus.inc_ctr, e_inc);
            chk("ks_valid", bus.ks_valid, e_valid);
            chk("addr", bus.addr, e_addr);
            chk("ks_data", bus.ks_data, e_data);
            chk("ks_last", bus.ks_last, e_last);
            if (bus.inc_ctr) n_inc++;
        end
    end

    task automatic step1();
        @(posedge clk);
        #2;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step1();
    endtask

    task automatic run_until_done(input int t0, input int budget, output int lat);
        lat = -1;
        while (cyc < t0 + budget) begin
            step1();
            if (bus.done) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int lim;
        lim = cyc + budget;
        while (bus.busy && cyc < lim) step1();
        chk("idle_reached", bus.busy, 1'b0);
    endtask

    initial begin
        int t0, lat, inc0, d1, ndone;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
`ifdef CHACHA_XOR_EN
            pt_mem[i] = 8'($urandom);
`endif
        end
        bus.start    = 1'b0;
        bus.ks_ready = 1'b1;
        rst = 1'b1;
        goto(3);
        rst = 1'b0;
        chk_en = 1'b1;
        goto(6);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_valid", bus.ks_valid, 1'b0);

        // block 1, ready tied high
        t0 = cyc;
        bus.start = 1'b1;
        step1();
        bus.start = 1'b0;
        chk("lit_clear", bus.clear, 1'b1);
        goto(t0 + 2);
        chk("lit_calc", bus.calc, 1'b1);
        chk("lit_step0", bus.step, 2'd0);
        goto(t0 + 6);
        chk("lit_shift", bus.shift, 1'b1);
        chk("lit_shift_ctr0", bus.shift_ctr, 5'd0);
        chk("lit_dir0", bus.shift_dir, 1'b0);
        goto(t0 + 42);
        chk("lit_dir1", bus.shift_dir, 1'b1);
        goto(t0 + 722);
        chk("lit_addb", bus.add_back, 1'b1);
        goto(t0 + 723);
        chk("lit_first_valid", bus.ks_valid, 1'b1);
        chk("lit_first_addr", bus.addr, 6'd0);
        goto(t0 + 786);
        chk("lit_last", bus.ks_last, 1'b1);
        chk("lit_last_addr", bus.addr, 6'd63);
        run_until_done(t0, 1000, lat);
        chk("done_lat", lat, 787);

        // block 2, five stall cycles on byte 10
        step1();
        t0 = cyc;
        bus.start = 1'b1;
        step1();
        bus.start = 1'b0;
        goto(t0 + 733);
        bus.ks_ready = 1'b0;
        goto(t0 + 735);
        chk("stall_addr", bus.addr, 6'd10);
        chk("stall_data", bus.ks_data, exp_byte(10));
        goto(t0 + 738);
        bus.ks_ready = 1'b1;
        run_until_done(t0, 1000, lat);
        chk("stall_done_lat", lat, 792);

        // back-to-back with start held and random ready
        step1();
        inc0 = n_inc;
        d1 = -10;
        ndone = 0;
        t0 = cyc;
        bus.start = 1'b1;
        while (ndone < 2 && cyc < t0 + 4000) begin
            step1();
            bus.ks_ready = ($urandom_range(0, 3) != 0);
            if (cyc == d1 + 2) chk("b2b_clear", bus.clear, 1'b1);
            if (bus.done) begin
                ndone++;
                d1 = cyc;
            end
        end
        bus.start = 1'b0;
        bus.ks_ready = 1'b1;
        chk("b2b_blocks", ndone, 2);
        wait_idle(2000);
        chk("b2b_inc", n_inc - inc0, 2);

        // reset during round 7 SHIFT, then a fresh block
        step1();
        t0 = cyc;
        bus.start = 1'b1;
        step1();
        bus.start = 1'b0;
        goto(t0 + 6 + 36 * 7 + 10);
        chk("pre_rst_shift", bus.shift, 1'b1);
        rst = 1'b1;
        step1();
        rst = 1'b0;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_shift", bus.shift, 1'b0);
        chk("rst_shift_ctr", bus.shift_ctr, 5'd0);
        step1();
        t0 = cyc;
        bus.start = 1'b1;
        step1();
        bus.start = 1'b0;
        goto(t0 + 723);
        chk("rst_first_addr", bus.addr, 6'd0);
        chk("rst_first_data", bus.ks_data, exp_byte(0));
        run_until_done(t0, 1000, lat);
        chk("rst_done_lat", lat, 787);

        // random traffic: start pulses, ready stalls, rare resets
        for (int i = 0; i < 6000; i++) begin
            step1();
            rst          = ($urandom_range(0, 2999) == 0);
            bus.start    = ($urandom_range(0, 39) == 0);
            bus.ks_ready = ($urandom_range(0, 3) != 0);
        end
        step1();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.ks_ready = 1'b1;
        wait_idle(2000);
        step1();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
